// File: rtl/spi_cmd_dispatch_pkg.sv
// Shared types for the SPI command dispatcher: opcodes, FSM states, fixed response words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_cmd_dispatch_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_WRITE = 4'h1,
        OP_READ  = 4'h2,
        OP_START = 4'h3,
        OP_CLR   = 4'h4
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    localparam word_t RESP_ERR   = 16'hEEEE;
    localparam word_t RESP_START = 16'h3000;

    // Response carrying the status nibble in the low bits, opcode echoed on top.
    function automatic word_t mk_status_resp(input opcode_e op, input logic [3:0] status);
        return {op, 8'h00, status};
    endfunction

endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// Command/response bundle between the SPI slave, the dispatcher and the acquisition engine.
// Latency: n/a (wires only).
// Backpressure: none; cmd_rdy is a fire-and-forget pulse, start_req is held until eng_ack.
interface spi_cmd_dispatch_if;
    import spi_cmd_dispatch_pkg::*;

    word_t cmd;
    logic  cmd_rdy;
    logic  eng_ack;
    word_t resp;
    logic  resp_vld;
    logic  start_req;

    // Side that issues commands and acks (SPI slave + engine).
    modport master (
        output cmd, cmd_rdy, eng_ack,
        input  resp, resp_vld, start_req
    );

    // Dispatcher side.
    modport slave (
        input  cmd, cmd_rdy, eng_ack,
        output resp, resp_vld, start_req
    );

endinterface

// File: rtl/spi_cmd_dispatch_fifo.sv
// Small synchronous FIFO buffering command words between the SPI slave and the dispatcher FSM.
// Latency: word pushed at edge k is visible on pop_dat after edge k.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q,    cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot a push into a full FIFO needs.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Pointer/count state; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Decodes buffered SPI command words, executes them on a config regfile / engine start handshake.
// Latency: cmd_rdy at edge k (idle, empty FIFO) -> resp/resp_vld at edge k+2; back-to-back one per cycle.
// Backpressure: none upstream; words arriving with the FIFO full are dropped and flagged on sticky ovf.
module spi_cmd_dispatch
    import spi_cmd_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREGS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_cmd_dispatch_if.slave  bus,
    output logic [NREGS*8-1:0] cfg_flat,
    output logic               ovf
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [4:0] NREGS_W = 5'(NREGS);

    state_e      state_q, state_d;
    word_t       cmd_q, cmd_d;
    word_t       resp_q, resp_d;
    logic        resp_vld_q, resp_vld_d;
    logic        start_req_q, start_req_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [7:0]  regs_q [NREGS];
    logic [7:0]  regs_d [NREGS];

    logic        fifo_pop;
    word_t       fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    logic [3:0]  opc;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [AW-1:0] ridx;
    logic        addr_ok;
    logic [3:0]  status4;
    logic        ovf_clr;
    logic        drop;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (bus.cmd_rdy),
        .push_dat (bus.cmd),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign opc     = cmd_q[15:12];
    assign addr    = cmd_q[11:8];
    assign data    = cmd_q[7:0];
    assign ridx    = addr[AW-1:0];
    assign addr_ok = ({1'b0, addr} < NREGS_W);
    assign status4 = {ovf_q, err_q, fifo_full, fifo_empty};

    assign bus.resp      = resp_q;
    assign bus.resp_vld  = resp_vld_q;
    assign bus.start_req = start_req_q;
    assign ovf           = ovf_q;

    // Next-state, execution and FIFO pop decision; a command is fetched on the same edge it is popped.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        resp_d      = resp_q;
        resp_vld_d  = 1'b0;
        start_req_d = start_req_q;
        regs_d      = regs_q;
        err_d       = err_q;
        ovf_clr     = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d    = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                resp_vld_d = 1'b1;
                case (opc)
                    OP_NOP: begin
                        resp_d = mk_status_resp(OP_NOP, status4);
                    end
                    OP_WRITE: begin
                        if (addr_ok) begin
                            regs_d[ridx] = data;
                            resp_d       = cmd_q;
                        end else begin
                            resp_d = RESP_ERR;
                            err_d  = 1'b1;
                        end
                    end
                    OP_READ: begin
                        if (addr_ok) begin
                            resp_d = {OP_READ, addr, regs_q[ridx]};
                        end else begin
                            resp_d = RESP_ERR;
                            err_d  = 1'b1;
                        end
                    end
                    OP_START: begin
                        // Response for START is deferred until the engine acks.
                        resp_vld_d  = 1'b0;
                        start_req_d = 1'b1;
                    end
                    OP_CLR: begin
                        resp_d  = mk_status_resp(OP_CLR, status4);
                        ovf_clr = 1'b1;
                        err_d   = 1'b0;
                    end
                    default: begin
                        resp_d = RESP_ERR;
                        err_d  = 1'b1;
                    end
                endcase

                if (opc == OP_START) begin
                    state_d = ST_WAIT_ACK;
                end else if (!fifo_empty) begin
                    cmd_d    = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_ACK: begin
                if (bus.eng_ack) begin
                    start_req_d = 1'b0;
                    resp_d      = RESP_START;
                    resp_vld_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh drop outranks a CLR executing on the same edge.
        drop  = bus.cmd_rdy && fifo_full && !fifo_pop;
        ovf_d = (ovf_q && !ovf_clr) || drop;
    end

    // Control and datapath registers; reset overrides every event on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            resp_q      <= '0;
            resp_vld_q  <= 1'b0;
            start_req_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            resp_vld_q  <= resp_vld_d;
            start_req_q <= start_req_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    // Flatten the register file onto the config bus, reg i at byte i.
    always_comb begin
        cfg_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            cfg_flat[i*8 +: 8] = regs_q[i];
        end
    end

endmodule
